// File: rtl/sprite_pkg.sv
// Shared types and constants for the player-sprite pixel stage.
// Frame-ID layout: walk frames 0..7, attack frames 8..23.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    ATTACK = 2'd2
  } anim_state_t;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [4:0] WALK_BASE   = 5'd0;
  localparam logic [4:0] ATTACK_BASE = 5'd8;
  localparam int         SPRITE_DIM  = 32;

  // Index 0 is transparent, so its colour is never shown.
  localparam logic [11:0] SPRITE_PALETTE [8] = '{
    12'h000, 12'hFDB, 12'h0A0, 12'h060,
    12'h850, 12'hFF0, 12'hCCC, 12'h222
  };

endpackage

// File: rtl/sprite_anim_fsm.sv
// Animation state machine: idle / walk / sword attack, advanced by frame ticks.
// Leaving IDLE or WALK is immediate; everything else waits for a frame tick.
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int WALK_PERIOD   = 8,
  parameter int ATTACK_PERIOD = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] dir,
  input  logic       moving,
  input  logic       attack_req,
  output logic [4:0] frame_id,
  output logic       attack_busy
);

  anim_state_t state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  dir_t        atk_dir_q, atk_dir_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tick_cnt_d = tick_cnt_q;
    atk_dir_d  = atk_dir_q;
    case (state_q)
      IDLE: begin
        phase_d    = 2'd0;
        tick_cnt_d = 8'd0;
        if (attack_req) begin
          state_d   = ATTACK;
          atk_dir_d = dir_t'(dir);
        end else if (moving) begin
          state_d = WALK;
        end
      end
      WALK: begin
        if (attack_req) begin
          state_d    = ATTACK;
          atk_dir_d  = dir_t'(dir);
          phase_d    = 2'd0;
          tick_cnt_d = 8'd0;
        end else if (!moving) begin
          state_d    = IDLE;
          phase_d    = 2'd0;
          tick_cnt_d = 8'd0;
        end else if (frame_tick) begin
          if (tick_cnt_q == 8'(WALK_PERIOD - 1)) begin
            tick_cnt_d = 8'd0;
            phase_d    = {1'b0, ~phase_q[0]};
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      ATTACK: begin
        if (frame_tick) begin
          if (tick_cnt_q == 8'(ATTACK_PERIOD - 1)) begin
            tick_cnt_d = 8'd0;
            if (phase_q == 2'd3) begin
              state_d = moving ? WALK : IDLE;
              phase_d = 2'd0;
            end else begin
              phase_d = phase_q + 2'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        phase_d    = 2'd0;
        tick_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= 2'd0;
      tick_cnt_q <= 8'd0;
      atk_dir_q  <= DIR_DOWN;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      atk_dir_q  <= atk_dir_d;
    end
  end

  // Attack frames use the latched direction; walk/idle follow dir live.
  always_comb begin
    if (state_q == ATTACK) begin
      frame_id = ATTACK_BASE + {1'b0, atk_dir_q, phase_q};
    end else begin
      frame_id = WALK_BASE + {2'b00, dir, phase_q[0]};
    end
  end

  assign attack_busy = (state_q == ATTACK);

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Player-sprite pixel stage: scan position -> ROM address/frame, ROM index -> RGB.
// Three-stage pipeline at full throughput around the one-cycle sprite ROM.
module sprite_pixel_pipe
  import sprite_pkg::*;
#(
  parameter int WALK_PERIOD   = 8,
  parameter int ATTACK_PERIOD = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [1:0]  dir,
  input  logic        moving,
  input  logic        attack_req,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  output logic [9:0]  rom_addr,
  output logic [4:0]  frame_id,
  output logic [4:0]  frame_id_q,
  input  logic [2:0]  rom_q,
  output logic [11:0] pixel_rgb,
  output logic        pixel_opaque,
  output logic        attack_busy
);

  logic [4:0]  fsm_frame_id;
  logic [10:0] dx, dy;
  logic        hit;

  logic [9:0]  rom_addr_q, rom_addr_d;
  logic [4:0]  frame_s1_q, frame_s1_d;
  logic [4:0]  frame_s2_q, frame_s2_d;
  logic        hit_s1_q, hit_s1_d;
  logic        hit_s2_q, hit_s2_d;
  logic [11:0] pixel_rgb_q, pixel_rgb_d;
  logic        pixel_opaque_q, pixel_opaque_d;

  sprite_anim_fsm #(
    .WALK_PERIOD   (WALK_PERIOD),
    .ATTACK_PERIOD (ATTACK_PERIOD)
  ) u_anim_fsm (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .dir         (dir),
    .moving      (moving),
    .attack_req  (attack_req),
    .frame_id    (fsm_frame_id),
    .attack_busy (attack_busy)
  );

  // A negative offset wraps to a large unsigned value, so one compare covers both edges.
  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, sprite_x};
    dy  = {1'b0, draw_y} - {1'b0, sprite_y};
    hit = (dx < 11'(SPRITE_DIM)) && (dy < 11'(SPRITE_DIM));

    rom_addr_d     = hit ? {dy[4:0], dx[4:0]} : 10'd0;
    frame_s1_d     = fsm_frame_id;
    hit_s1_d       = hit;
    frame_s2_d     = frame_s1_q;
    hit_s2_d       = hit_s1_q;
    pixel_opaque_d = hit_s2_q && (rom_q != 3'd0);
    pixel_rgb_d    = pixel_opaque_d ? SPRITE_PALETTE[rom_q] : 12'h000;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rom_addr_q     <= 10'd0;
      frame_s1_q     <= 5'd0;
      frame_s2_q     <= 5'd0;
      hit_s1_q       <= 1'b0;
      hit_s2_q       <= 1'b0;
      pixel_rgb_q    <= 12'h000;
      pixel_opaque_q <= 1'b0;
    end else begin
      rom_addr_q     <= rom_addr_d;
      frame_s1_q     <= frame_s1_d;
      frame_s2_q     <= frame_s2_d;
      hit_s1_q       <= hit_s1_d;
      hit_s2_q       <= hit_s2_d;
      pixel_rgb_q    <= pixel_rgb_d;
      pixel_opaque_q <= pixel_opaque_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign frame_id     = frame_s1_q;
  assign frame_id_q   = frame_s2_q;
  assign pixel_rgb    = pixel_rgb_q;
  assign pixel_opaque = pixel_opaque_q;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Self-checking bench for sprite_pixel_pipe: directed test-plan steps plus randomized
// traffic, all checked every cycle against a tick-counting reference model.
module tb_sprite_pixel_pipe;

  localparam int WALK_P = 8;
  localparam int ATK_P  = 4;
  localparam logic [11:0] PAL [8] = '{
    12'h000, 12'hFDB, 12'h0A0, 12'h060,
    12'h850, 12'hFF0, 12'hCCC, 12'h222
  };

  logic        clock;
  logic        reset;
  logic        frame_tick;
  logic [1:0]  dir;
  logic        moving;
  logic        attack_req;
  logic [9:0]  sprite_x, sprite_y, draw_x, draw_y;
  logic [9:0]  rom_addr;
  logic [4:0]  frame_id, frame_id_q;
  logic [2:0]  rom_q;
  logic [11:0] pixel_rgb;
  logic        pixel_opaque;
  logic        attack_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 8;
  bit rand_pix = 0;

  // Reference model: mode 0 idle, 1 walk, 2 attack; ticks counted since mode entry.
  int m_mode, m_walk_ticks, m_atk_ticks, m_atk_dir;
  bit hit_hist [8];
  int frame_hist [8];

  logic [9:0]  exp_addr;
  logic [4:0]  exp_frame, exp_frame_q;
  logic        exp_opaque, exp_busy;
  logic [11:0] exp_rgb;

  sprite_pixel_pipe #(
    .WALK_PERIOD   (WALK_P),
    .ATTACK_PERIOD (ATK_P)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .dir          (dir),
    .moving       (moving),
    .attack_req   (attack_req),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .rom_addr     (rom_addr),
    .frame_id     (frame_id),
    .frame_id_q   (frame_id_q),
    .rom_q        (rom_q),
    .pixel_rgb    (pixel_rgb),
    .pixel_opaque (pixel_opaque),
    .attack_busy  (attack_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int model_frame(int d);
    case (m_mode)
      1:       return d * 2 + (m_walk_ticks / WALK_P) % 2;
      2:       return 8 + m_atk_dir * 4 + m_atk_ticks / ATK_P;
      default: return d * 2;
    endcase
  endfunction

  task automatic model_update();
    case (m_mode)
      0: begin
        if (attack_req) begin
          m_mode = 2; m_atk_ticks = 0; m_atk_dir = int'(dir);
        end else if (moving) begin
          m_mode = 1; m_walk_ticks = 0;
        end
      end
      1: begin
        if (attack_req) begin
          m_mode = 2; m_atk_ticks = 0; m_atk_dir = int'(dir);
        end else if (!moving) begin
          m_mode = 0;
        end else if (frame_tick) begin
          m_walk_ticks++;
        end
      end
      default: begin
        if (frame_tick) begin
          m_atk_ticks++;
          if (m_atk_ticks == 4 * ATK_P) begin
            m_mode = moving ? 1 : 0;
            m_walk_ticks = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check_eq("rom_addr",     32'(rom_addr),     32'(exp_addr));
    check_eq("frame_id",     32'(frame_id),     32'(exp_frame));
    check_eq("frame_id_q",   32'(frame_id_q),   32'(exp_frame_q));
    check_eq("pixel_opaque", 32'(pixel_opaque), 32'(exp_opaque));
    check_eq("pixel_rgb",    32'(pixel_rgb),    32'(exp_rgb));
    check_eq("attack_busy",  32'(attack_busy),  32'(exp_busy));
  endtask

  task automatic applyStimulus(input bit tick, input bit mv, input bit atk, input logic [1:0] d);
    frame_tick = tick;
    moving     = mv;
    attack_req = atk;
    dir        = d;
  endtask

  // One clock: derive expectations from the inputs about to be sampled, clock, then compare.
  task automatic step();
    int n, dx, dy;
    bit hit;
    cyc++;
    n = cyc;
    if (rand_pix) begin
      draw_x = sprite_x + 10'($urandom_range(0, 40)) - 10'd4;
      draw_y = sprite_y + 10'($urandom_range(0, 40)) - 10'd4;
      rom_q  = 3'($urandom_range(0, 7));
    end
    if (reset) begin
      hit_hist[n % 8]       = 1'b0;
      hit_hist[(n - 1) % 8] = 1'b0;
      frame_hist[n % 8]     = 0;
      m_mode = 0; m_walk_ticks = 0; m_atk_ticks = 0; m_atk_dir = 0;
      exp_addr = '0; exp_frame = '0; exp_frame_q = '0;
      exp_opaque = 1'b0; exp_rgb = '0; exp_busy = 1'b0;
    end else begin
      dx  = int'(draw_x) - int'(sprite_x);
      dy  = int'(draw_y) - int'(sprite_y);
      hit = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
      hit_hist[n % 8]   = hit;
      exp_addr          = hit ? 10'(dy * 32 + dx) : 10'd0;
      frame_hist[n % 8] = model_frame(int'(dir));
      exp_frame         = 5'(frame_hist[n % 8]);
      exp_frame_q       = 5'(frame_hist[(n - 1) % 8]);
      exp_opaque        = hit_hist[(n - 2) % 8] && (rom_q != 3'd0);
      exp_rgb           = exp_opaque ? PAL[rom_q] : 12'h000;
      model_update();
      exp_busy          = (m_mode == 2);
    end
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic ticks(int k, int gap);
    for (int i = 0; i < k; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int j = 0; j < gap; j++) step();
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    sprite_x = 10'd0; sprite_y = 10'd0; draw_x = 10'd0; draw_y = 10'd0; rom_q = 3'd0;
    for (int i = 0; i < 8; i++) begin hit_hist[i] = 1'b0; frame_hist[i] = 0; end
    m_mode = 0; m_walk_ticks = 0; m_atk_ticks = 0; m_atk_dir = 0;

    $display("[TB] reset");
    step();
    step();
    check_eq("reset_addr", 32'(rom_addr), 32'd0);
    check_eq("reset_busy", 32'(attack_busy), 32'd0);
    reset = 1'b0;

    $display("[TB] hit test corners");
    sprite_x = 10'd100; sprite_y = 10'd100;
    rom_q = 3'd3;
    draw_x = 10'd100; draw_y = 10'd100; step();
    check_eq("addr_origin", 32'(rom_addr), 32'd0);
    draw_x = 10'd131; draw_y = 10'd131; step();
    check_eq("addr_corner", 32'(rom_addr), 32'd1023);
    draw_x = 10'd132; draw_y = 10'd100; step();
    check_eq("addr_dx32", 32'(rom_addr), 32'd0);
    draw_x = 10'd0; draw_y = 10'd0; step(); step();
    check_eq("opaque_dx32", 32'(pixel_opaque), 32'd0);

    sprite_x = 10'd5; sprite_y = 10'd5;
    draw_x = 10'd3; draw_y = 10'd5; step();
    check_eq("addr_neg_dx", 32'(rom_addr), 32'd0);
    rom_q = 3'd7; draw_x = 10'd0; draw_y = 10'd0; step(); step();
    check_eq("opaque_neg_dx", 32'(pixel_opaque), 32'd0);
    draw_x = 10'd10; draw_y = 10'd6; step();
    draw_x = 10'd0; draw_y = 10'd0; step();
    rom_q = 3'd0; step();
    check_eq("opaque_idx0", 32'(pixel_opaque), 32'd0);
    draw_x = 10'd12; draw_y = 10'd7; step();
    draw_x = 10'd0; draw_y = 10'd0; step();
    rom_q = 3'd5; step();
    check_eq("opaque_idx5", 32'(pixel_opaque), 32'd1);
    check_eq("rgb_idx5", 32'(pixel_rgb), 32'(PAL[5]));

    $display("[TB] walk cycle");
    rand_pix = 1'b1;
    sprite_x = 10'd200; sprite_y = 10'd150;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    step(); step();
    check_eq("walk_start", 32'(frame_id), 32'd6);
    ticks(8, 2);
    check_eq("walk_phase1", 32'(frame_id), 32'd7);
    ticks(8, 2);
    check_eq("walk_phase0", 32'(frame_id), 32'd6);
    moving = 1'b0; step(); step();
    check_eq("idle_frame", 32'(frame_id), 32'd6);

    $display("[TB] sword attack");
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1);
    step();
    attack_req = 1'b0;
    check_eq("atk_busy", 32'(attack_busy), 32'd1);
    step();
    check_eq("atk_p0", 32'(frame_id), 32'd12);
    ticks(4, 2);
    check_eq("atk_p1", 32'(frame_id), 32'd13);
    dir = 2'd0;
    ticks(4, 2);
    check_eq("atk_p2_dir_ignored", 32'(frame_id), 32'd14);
    ticks(4, 2);
    check_eq("atk_p3", 32'(frame_id), 32'd15);
    ticks(4, 2);
    check_eq("atk_done_busy", 32'(attack_busy), 32'd0);
    check_eq("atk_done_frame", 32'(frame_id), 32'd0);

    $display("[TB] attack entry on a tick, then reset mid-attack");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd2);
    ticks(3, 2);
    check_eq("entry_tick_p0", 32'(frame_id), 32'd16);
    ticks(1, 2);
    check_eq("entry_tick_p1", 32'(frame_id), 32'd17);
    ticks(4, 2);
    check_eq("mid_p2", 32'(frame_id), 32'd18);
    ticks(2, 1);
    reset = 1'b1; step();
    reset = 1'b0;
    check_eq("rst_addr",   32'(rom_addr),     32'd0);
    check_eq("rst_frame",  32'(frame_id),     32'd0);
    check_eq("rst_frameq", 32'(frame_id_q),   32'd0);
    check_eq("rst_rgb",    32'(pixel_rgb),    32'd0);
    check_eq("rst_opaque", 32'(pixel_opaque), 32'd0);
    check_eq("rst_busy",   32'(attack_busy),  32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
    step();
    attack_req = 1'b0;
    check_eq("restart_busy", 32'(attack_busy), 32'd1);
    step();
    check_eq("restart_p0", 32'(frame_id), 32'd8);
    ticks(16, 1);
    check_eq("restart_done", 32'(attack_busy), 32'd0);
    check_eq("restart_walk", 32'(frame_id), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) moving = ~moving;
      if ($urandom_range(0, 7) == 0) dir = 2'($urandom_range(0, 3));
      attack_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 63) == 0) begin
        sprite_x = 10'($urandom_range(0, 1023));
        sprite_y = 10'($urandom_range(0, 1023));
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_pipe.md
# sprite_pixel_pipe

Player-sprite pixel stage that sits directly upstream of the 32x32 sprite ROM bank (walk and sword frames, 1024 x 3-bit palette-index ROMs, one-cycle synchronous read). Tracks the animation state (idle / walk / sword attack) once per video frame and turns the VGA scan position into a ROM address and frame select. After the ROM returns its index, the block converts it through the sprite palette into an opaque/transparent RGB pixel for the background compositor.

## Interface

- `WALK_PERIOD`, default 8: frame ticks per walk phase toggle.
- `ATTACK_PERIOD`, default 4: frame ticks per sword phase.
- `clock`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `frame_tick`  in  1: one-cycle pulse per video frame (vsync edge).
- `dir`  in  2: 0 down, 1 up, 2 left, 3 right.
- `moving`  in  1: movement key held.
- `attack_req`  in  1: sword request, level or pulse.
- `sprite_x`, `sprite_y`  in  10 each: sprite top-left, in screen pixels.
- `draw_x`, `draw_y`  in  10 each: current scan position, one new pixel per clock.
- `rom_addr`  out  10: ROM address, registered.
- `frame_id`  out  5: frame select aligned with `rom_addr`. Walk frames are `dir*2+phase` (0..7). Attack frames are `8+dir*4+phase` (8..23).
- `frame_id_q`  out  5: `frame_id` delayed one cycle. The top-level q-mux uses it.
- `rom_q`  in  3: palette index from the muxed ROM.
- `pixel_rgb`  out  12: {R4,G4,B4}.
- `pixel_opaque`  out  1: sprite covers this pixel and the index is non-zero.
- `attack_busy`  out  1: high while the FSM is in ATTACK.

## Operation

- FSM states are IDLE, WALK and ATTACK. The FSM holds a `phase` register (2 bits) and a tick counter (8 bits) that counts `frame_tick` pulses only.
- IDLE:
  - phase = 0.
  - `attack_req` goes to ATTACK; this has priority over `moving`.
  - Else `moving` goes to WALK.
- WALK:
  - Every `WALK_PERIOD` ticks, phase toggles between 0 and 1.
  - `attack_req` goes to ATTACK.
  - `!moving` goes to IDLE with phase 0 and the counter cleared.
  - A change of `dir` takes effect immediately; phase is kept.
- ATTACK:
  - On entry, `dir` is latched, phase = 0 and the counter is cleared.
  - Phase advances 0 to 3, one step every `ATTACK_PERIOD` ticks.
  - After the last tick of phase 3, the FSM goes to WALK if `moving`, else IDLE.
  - `attack_req` and `dir` are ignored while in ATTACK.
- Hit test:
  - dx = draw_x − sprite_x and dy = draw_y − sprite_y, each as an 11-bit two's-complement value.
  - hit = both values in 0..31.
  - rom_addr = {dy[4:0], dx[4:0]} when hit, else 0.
- Palette index 0 is transparent. Indices 1..7 map through the constant palette to `pixel_rgb`. When not opaque, `pixel_rgb` = 0.

## Timing

- Pixel pipeline, with draw position presented at cycle t:
  - `rom_addr`, `frame_id` and hit_s1 registered at t+1.
  - `rom_q` valid at t+2; `frame_id_q` and hit_s2 are aligned with it.
  - `pixel_rgb` and `pixel_opaque` registered at t+3.
  - Fixed latency of 3 with full throughput; there is no stall.
- FSM state and phase change only on cycles with `frame_tick` = 1, with one exception: a transition out of IDLE or WALK happens on the first cycle its condition holds.
- A `frame_tick` on the same cycle as an ATTACK entry is not counted.
- Reset (all registers, including mid-attack):
  - FSM to IDLE; phase, counter and pipeline hit bits to 0.
  - `rom_addr`, `frame_id`, `frame_id_q`, `pixel_rgb`, `pixel_opaque` and `attack_busy` all 0.
- Boundary cases:
  - `sprite_x` > `draw_x` gives negative dx, so no hit.
  - A sprite partially off-screen right or bottom is clipped naturally by the scan range.
  - dx = 32 is not a hit.

## Structure

- Package `sprite_pkg` holds:
  - the `anim_state_t` enum (IDLE, WALK, ATTACK);
  - the `dir_t` encoding;
  - the frame-ID base constants `WALK_BASE`=0 and `ATTACK_BASE`=8;
  - `SPRITE_DIM`=32;
  - the 8-entry 12-bit `SPRITE_PALETTE` constant array.
- Sub-module `sprite_anim_fsm` holds the FSM, tick counter, phase and latched direction. It outputs `frame_id` (combinational) and `attack_busy`.
- The pixel pipeline is the top-level body.

## Test plan

- Reset, then sprite at (100,100) and draw (100,100) → `rom_addr`=0 at t+1. Draw (131,131) → addr 1023. Draw (132,100) → not hit, addr 0, `pixel_opaque`=0 at t+3.
- Sprite at (5,5), draw (3,5) → negative dx, no hit. Drive `rom_q`=0 on a hit pixel → `pixel_opaque`=0. `rom_q`=5 → `pixel_rgb`=`SPRITE_PALETTE[5]` exactly 3 cycles after the draw position.
- `moving`=1, `dir`=3 → `frame_id` 6. After 8 ticks → 7, after 16 ticks → 6. Drop `moving` → IDLE, `frame_id`=6.
- `attack_req` pulse with `dir`=1 → `attack_busy`=1 and `frame_id` sequence 12,13,14,15, 4 ticks each. Change `dir` mid-attack → no effect. After 16 ticks → IDLE, busy=0.
- `attack_req` asserted on the same cycle as `frame_tick` → that tick is not counted; phase 0 lasts exactly 4 further ticks.
- Assert `reset` during ATTACK phase 2 → the next cycle shows all outputs 0 and state IDLE. Attack restarts cleanly afterward.
